// File: rtl/scene_controller.sv
// Game scene sequencer for the VGA display block: scene FSM, player position, two falling objects,
// catch/miss detection once per frame. Optional build macro SCENE_TIMEOUT_EN adds a PLAY frame limit.
module scene_controller #(
  parameter int unsigned SCR_W          = 640,
  parameter int unsigned SCR_H          = 480,
  parameter int unsigned PIC_W          = 64,
  parameter int unsigned PIC_H          = 64,
  parameter int unsigned OBJ_SIZE       = 40,
  parameter int unsigned OBJ_STEP       = 2,
  parameter int unsigned PLAYER_STEP    = 4,
  parameter int unsigned OBJ1_X0        = 100,
  parameter int unsigned OBJ2_X0        = 500,
`ifdef SCENE_TIMEOUT_EN
  parameter int unsigned OBJ2_DELAY     = 60,
  parameter int unsigned TIMEOUT_FRAMES = 1800
`else
  parameter int unsigned OBJ2_DELAY     = 60
`endif
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_start,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [2:0]  state,
  output logic [11:0] x_begin,
  output logic [11:0] y_begin,
  output logic [11:0] obj1_x_begin,
  output logic [11:0] obj1_y_begin,
  output logic [11:0] obj2_x_begin,
  output logic [11:0] obj2_y_begin,
  output logic        end_show1,
  output logic        end_show2,
  output logic [1:0]  score
);

  localparam int unsigned PW  = 12;
  localparam int unsigned EW  = 13;
  localparam int unsigned FCW = 11;

  localparam logic [PW-1:0] X_INIT = PW'((SCR_W - PIC_W) / 2);
  localparam logic [PW-1:0] X_MAX  = PW'(SCR_W - PIC_W);
  localparam logic [PW-1:0] Y_PLR  = PW'(SCR_H - PIC_H);
  localparam logic [PW-1:0] P_STEP = PW'(PLAYER_STEP);
  localparam logic [PW-1:0] O_STEP = PW'(OBJ_STEP);

  localparam logic [EW-1:0] E_PW  = EW'(PIC_W);
  localparam logic [EW-1:0] E_PH  = EW'(PIC_H);
  localparam logic [EW-1:0] E_OS  = EW'(OBJ_SIZE);
  localparam logic [EW-1:0] E_SH  = EW'(SCR_H);
  localparam logic [EW-1:0] E_PY  = EW'(SCR_H - PIC_H);
  localparam logic [EW-1:0] E_O1X = EW'(OBJ1_X0);
  localparam logic [EW-1:0] E_O2X = EW'(OBJ2_X0);

  localparam logic [FCW-1:0] FC_DELAY = FCW'(OBJ2_DELAY);
`ifdef SCENE_TIMEOUT_EN
  localparam logic [FCW-1:0] FC_SAT  = {FCW{1'b1}};
  localparam logic [FCW-1:0] FC_TOUT = FCW'(TIMEOUT_FRAMES);
`else
  localparam logic [FCW-1:0] FC_SAT  = FCW'(OBJ2_DELAY);
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_PLAY = 3'b010,
    S_WIN  = 3'b100,
    S_LOSE = 3'b101
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  px_q, px_d;
  logic [PW-1:0]  o1y_q, o1y_d;
  logic [PW-1:0]  o2y_q, o2y_d;
  logic           hide1_q, hide1_d;
  logic           hide2_q, hide2_d;
  logic [1:0]     score_q, score_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic           start_prev_q;
  logic           eval_q, eval_d;

  logic start_edge;
  logic catch1, catch2, miss1, miss2;

  // Overlap of a 40x40 object with the player picture, all in 13-bit to keep sums exact
  function automatic logic overlap(input logic [EW-1:0] ox, input logic [EW-1:0] oy,
                                   input logic [EW-1:0] px);
    overlap = (ox < px + E_PW) && (ox + E_OS > px) &&
              (oy < E_PY + E_PH) && (oy + E_OS > E_PY);
  endfunction

  assign start_edge = btn_start & ~start_prev_q;

  always_comb begin
    catch1 = ~hide1_q & overlap(E_O1X, EW'(o1y_q), EW'(px_q));
    catch2 = ~hide2_q & overlap(E_O2X, EW'(o2y_q), EW'(px_q));
    miss1  = ~hide1_q & ~catch1 & (EW'(o1y_q) + E_OS >= E_SH);
    miss2  = ~hide2_q & ~catch2 & (EW'(o2y_q) + E_OS >= E_SH);
  end

  // Next-state and datapath: first cycle after a tick moves, second cycle evaluates
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    o1y_d   = o1y_q;
    o2y_d   = o2y_q;
    hide1_d = hide1_q;
    hide2_d = hide2_q;
    score_d = score_q;
    fc_d    = fc_q;
    eval_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_PLAY;
          px_d    = X_INIT;
          o1y_d   = '0;
          o2y_d   = '0;
          hide1_d = 1'b0;
          hide2_d = 1'b0;
          score_d = '0;
          fc_d    = '0;
        end
      end

      S_PLAY: begin
        if (eval_q) begin
          hide1_d = hide1_q | catch1;
          hide2_d = hide2_q | catch2;
          score_d = score_q + {1'b0, catch1} + {1'b0, catch2};
          if (miss1 || miss2) begin
            state_d = S_LOSE;
          end else if (hide1_d && hide2_d) begin
            state_d = S_WIN;
`ifdef SCENE_TIMEOUT_EN
          end else if (fc_q >= FC_TOUT) begin
            state_d = S_LOSE;
`endif
          end
        end else if (frame_tick) begin
          eval_d = 1'b1;
          if (btn_left && !btn_right) begin
            px_d = (px_q < P_STEP) ? '0 : px_q - P_STEP;
          end else if (btn_right && !btn_left) begin
            px_d = (px_q >= X_MAX - P_STEP) ? X_MAX : px_q + P_STEP;
          end
          if (!hide1_q) o1y_d = o1y_q + O_STEP;
          if (!hide2_q && fc_q >= FC_DELAY) o2y_d = o2y_q + O_STEP;
          if (fc_q != FC_SAT) fc_d = fc_q + FCW'(1);
        end
      end

      S_WIN, S_LOSE: begin
        if (start_edge) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      px_q         <= X_INIT;
      o1y_q        <= '0;
      o2y_q        <= '0;
      hide1_q      <= 1'b0;
      hide2_q      <= 1'b0;
      score_q      <= '0;
      fc_q         <= '0;
      start_prev_q <= 1'b0;
      eval_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      o1y_q        <= o1y_d;
      o2y_q        <= o2y_d;
      hide1_q      <= hide1_d;
      hide2_q      <= hide2_d;
      score_q      <= score_d;
      fc_q         <= fc_d;
      start_prev_q <= btn_start;
      eval_q       <= eval_d;
    end
  end

  assign state        = state_q;
  assign x_begin      = px_q;
  assign y_begin      = Y_PLR;
  assign obj1_x_begin = PW'(OBJ1_X0);
  assign obj1_y_begin = o1y_q;
  assign obj2_x_begin = PW'(OBJ2_X0);
  assign obj2_y_begin = o2y_q;
  assign end_show1    = hide1_q;
  assign end_show2    = hide2_q;
  assign score        = score_q;

endmodule

// File: tb/tb_scene_controller.sv
// Bench for scene_controller: frame-level reference model feeding a scoreboard queue,
// plus directed checks for reset, start-edge handling, loss, win and player clamping.
module tb_scene_controller;

  logic        clk_vga;
  logic        rst_n;
  logic        frame_tick;
  logic        btn_start;
  logic        btn_left;
  logic        btn_right;
  logic [2:0]  state;
  logic [11:0] x_begin, y_begin;
  logic [11:0] obj1_x_begin, obj1_y_begin, obj2_x_begin, obj2_y_begin;
  logic        end_show1, end_show2;
  logic [1:0]  score;

  scene_controller dut (
    .clk_vga      (clk_vga),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .btn_start    (btn_start),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .state        (state),
    .x_begin      (x_begin),
    .y_begin      (y_begin),
    .obj1_x_begin (obj1_x_begin),
    .obj1_y_begin (obj1_y_begin),
    .obj2_x_begin (obj2_x_begin),
    .obj2_y_begin (obj2_y_begin),
    .end_show1    (end_show1),
    .end_show2    (end_show2),
    .score        (score)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model (screen-level arithmetic in plain ints)
  int m_state, m_x, m_o1y, m_o2y, m_h1, m_h2, m_sc, m_fc;

  typedef struct {
    int st; int x; int o1y; int o2y; int h1; int h2; int sc;
  } exp_t;
  exp_t sbq[$];

  function automatic bit hits(input int ox, input int oy, input int px);
    return (ox < px + 64) && (ox + 40 > px) && (oy < 416 + 64) && (oy + 40 > 416);
  endfunction

  task automatic model_init();
    m_x = 288; m_o1y = 0; m_o2y = 0; m_h1 = 0; m_h2 = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_frame(input bit l, input bit r);
    bit c1, c2, ms1, ms2;
    if (m_state != 2) return;
    if (l && !r) m_x = (m_x >= 4) ? m_x - 4 : 0;
    if (r && !l) m_x = (m_x + 4 > 576) ? 576 : m_x + 4;
    if (m_h1 == 0) m_o1y += 2;
    if (m_h2 == 0 && m_fc >= 60) m_o2y += 2;
    m_fc++;
    c1  = (m_h1 == 0) && hits(100, m_o1y, m_x);
    c2  = (m_h2 == 0) && hits(500, m_o2y, m_x);
    ms1 = (m_h1 == 0) && !c1 && (m_o1y + 40 >= 480);
    ms2 = (m_h2 == 0) && !c2 && (m_o2y + 40 >= 480);
    if (c1) begin m_h1 = 1; m_sc++; end
    if (c2) begin m_h2 = 1; m_sc++; end
    if (ms1 || ms2) m_state = 5;
    else if (m_h1 == 1 && m_h2 == 1) m_state = 4;
`ifdef SCENE_TIMEOUT_EN
    else if (m_fc >= 1800) m_state = 5;
`endif
  endtask

  task automatic compare_out();
    exp_t e;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sbq.pop_front();
    check("st",     int'(state),        e.st);
    check("x",      int'(x_begin),      e.x);
    check("o1y",    int'(obj1_y_begin), e.o1y);
    check("o2y",    int'(obj2_y_begin), e.o2y);
    check("hide1",  int'(end_show1),    e.h1);
    check("hide2",  int'(end_show2),    e.h2);
    check("score",  int'(score),        e.sc);
  endtask

  // One frame: tick for one cycle, outputs settle two edges later
  task automatic run_frame(input bit l, input bit r);
    exp_t e;
    @(negedge clk_vga);
    btn_left = l; btn_right = r;
    model_frame(l, r);
    e.st = m_state; e.x = m_x; e.o1y = m_o1y; e.o2y = m_o2y;
    e.h1 = m_h1; e.h2 = m_h2; e.sc = m_sc;
    sbq.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk_vga);
    frame_tick = 1'b0;
    @(negedge clk_vga);
    compare_out();
    repeat (3) @(negedge clk_vga);
  endtask

  task automatic press_start();
    @(negedge clk_vga);
    btn_start = 1'b1;
    if (m_state == 1) begin model_init(); m_state = 2; end
    else if (m_state == 4 || m_state == 5) m_state = 1;
    @(negedge clk_vga);
    btn_start = 1'b0;
    check("start_state", int'(state), m_state);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, int'(state), 1);
    check({tag, "_x"},     int'(x_begin), 288);
    check({tag, "_y"},     int'(y_begin), 416);
    check({tag, "_o1x"},   int'(obj1_x_begin), 100);
    check({tag, "_o1y"},   int'(obj1_y_begin), 0);
    check({tag, "_o2x"},   int'(obj2_x_begin), 500);
    check({tag, "_o2y"},   int'(obj2_y_begin), 0);
    check({tag, "_hide"},  int'({end_show1, end_show2}), 0);
    check({tag, "_score"}, int'(score), 0);
  endtask

  initial begin
    int changes;
    int n;
    logic [2:0] prev_st;

    rst_n = 1'b0; frame_tick = 1'b0; btn_start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    m_state = 1; model_init();
    repeat (3) @(negedge clk_vga);
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_vga);

    // Start held for 100 cycles: exactly one IDLE->PLAY entry
    btn_start = 1'b1;
    changes = 0;
    prev_st = state;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_vga);
      if (state != prev_st) changes++;
      prev_st = state;
    end
    check("hold_changes", changes, 1);
    check("hold_state", int'(state), 2);
    model_init(); m_state = 2;
    btn_start = 1'b0;
    repeat (2) @(negedge clk_vga);
    press_start();
    check("repress_play", int'(state), 2);

    for (int i = 0; i < 10; i++) run_frame(1'b1, 1'b0);
    check("pre_reset_x", int'(x_begin), 248);

    // Reset mid-PLAY takes effect without a clock edge
    @(negedge clk_vga);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (3) @(negedge clk_vga);
    rst_n = 1'b1;
    m_state = 1; model_init();
    @(negedge clk_vga);
    check_reset_values("post_rst");

    // No buttons: object 1 reaches the bottom
    press_start();
    n = 0;
    while (m_state == 2 && n < 400) begin run_frame(1'b0, 1'b0); n++; end
    check("lose_budget", int'(m_state != 2), 1);
    check("lose_state", int'(state), 5);
    check("lose_o1y", int'(obj1_y_begin), 440);
    check("lose_o2y", int'(obj2_y_begin), 320);
    press_start();
    check("lose_hold_o1y", int'(obj1_y_begin), 440);

    // Catch both objects
    press_start();
    for (int i = 0; i < 40; i++) run_frame(1'b1, 1'b0);
    check("left40_x", int'(x_begin), 128);
    n = 0;
    while (m_state == 2 && m_h1 == 0 && n < 400) begin run_frame(1'b0, 1'b0); n++; end
    check("catch1_o1y", int'(obj1_y_begin), 378);
    check("catch1_hide", int'(end_show1), 1);
    check("catch1_score", int'(score), 1);
    n = 0;
    while (m_state == 2 && n < 100) begin run_frame(1'b0, 1'b1); n++; end
    while (m_state == 2 && n < 400) begin run_frame(1'b0, 1'b0); n++; end
    check("win_state", int'(state), 4);
    check("win_hide2", int'(end_show2), 1);
    check("win_score", int'(score), 2);

    // Both buttons cancel; left clamps at 0
    press_start();
    press_start();
    for (int i = 0; i < 10; i++) run_frame(1'b1, 1'b1);
    check("both_x", int'(x_begin), 288);
    for (int i = 0; i < 80; i++) run_frame(1'b1, 1'b0);
    check("clamp_x", int'(x_begin), 0);
    check("clamp_state", int'(state), 2);
    check("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
